// File: rtl/mycpu_pkg.sv
// Shared CPU-side constants for the data SRAM path: word width, read-latency bounds, reset read data.
// Build option: DATA_SRAM_BYTE_WE_EN selects per-byte write strobes (WE_W=4) instead of one word strobe.
package mycpu_pkg;

  localparam int WORD_W     = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam logic [WORD_W-1:0] RDATA_RST = 32'h0000_0000;

`ifdef DATA_SRAM_BYTE_WE_EN
  localparam int WE_W = 4;
`else
  localparam int WE_W = 1;
`endif

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE
  } acc_kind_e;

  // Any strobe bit set makes the access a write; an all-zero strobe is a read.
  function automatic acc_kind_e acc_kind(input logic en, input logic [WE_W-1:0] we);
    if (!en) return ACC_IDLE;
    return (|we) ? ACC_WRITE : ACC_READ;
  endfunction

endpackage

// File: rtl/data_sram_array.sv
// Single-port synchronous word RAM with write strobes and a registered read port.
// Build option: DATA_SRAM_BYTE_WE_EN makes each strobe bit write one byte lane.
module data_sram_array
  import mycpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [WE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // No reset on the storage; it relies on the zeroed power-up state of the RAM.
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
`ifdef DATA_SRAM_BYTE_WE_EN
        for (int b = 0; b < WE_W; b++) begin
          if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
`else
        mem[addr] <= wdata;
`endif
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM front end: RD_LAT-deep read-return pipeline, held read data and a sticky misalignment flag.
// Build option: DATA_SRAM_BYTE_WE_EN widens data_sram_we to per-byte strobes.
module data_sram_resp
  import mycpu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [WE_W-1:0]   data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [WORD_W-1:0] data_sram_wdata,
  output logic [WORD_W-1:0] data_sram_rdata,
  output logic              data_sram_rvalid,
  output logic              misalign_err
);

  // Out-of-range latencies are pinned to the nearest legal value.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  acc_kind_e         kind;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] last_data;
  logic [WORD_W-1:0] rdata_q;
  logic [LAT-1:0]    valid_q;
  logic              unused_addr_bits;

  // Requests presented while reset is held must not touch the array.
  assign kind             = acc_kind(data_sram_en & resetn, data_sram_we);
  assign unused_addr_bits = ^data_sram_addr[31:ADDR_W+2];

  data_sram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (kind != ACC_IDLE),
    .we    (data_sram_we),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= (kind == ACC_READ);
      for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // The array's output register is the first data stage; later stages just shift.
  generate
    if (LAT == 1) begin : g_no_pipe
      assign last_data = arr_rdata;
    end else begin : g_pipe
      logic [WORD_W-1:0] stage_q [LAT-1];
      always_ff @(posedge clk) begin
        stage_q[0] <= arr_rdata;
        for (int i = 1; i < LAT - 1; i++) stage_q[i] <= stage_q[i-1];
      end
      assign last_data = stage_q[LAT-2];
    end
  endgenerate

  assign data_sram_rvalid = valid_q[LAT-1];
  assign data_sram_rdata  = data_sram_rvalid ? last_data : rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q      <= RDATA_RST;
      misalign_err <= 1'b0;
    end else begin
      if (data_sram_rvalid) rdata_q <= last_data;
      if (kind != ACC_IDLE && data_sram_addr[1:0] != 2'b00) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: three instances (RD_LAT = 1, 2, 3) share one stimulus stream.
// Build option: DATA_SRAM_BYTE_WE_EN switches the strobe scenario to per-byte writes.
module tb_data_sram_resp;
  import mycpu_pkg::*;

  localparam int ADDR_W = 12;
  localparam int NDUT   = 3;
  localparam logic [WE_W-1:0] WE_ALL = '1;
  localparam logic [WE_W-1:0] WE_RD  = '0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic                   clk    = 1'b0;
  logic                   resetn = 1'b1;
  logic                   en     = 1'b0;
  logic [WE_W-1:0]        we     = '0;
  logic [31:0]            addr   = '0;
  logic [31:0]            wdata  = '0;
  logic [NDUT-1:0][31:0]  rdata_v;
  logic [NDUT-1:0]        rvalid_v;
  logic [NDUT-1:0]        err_v;

  int          cyc         = 0;
  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        exp_q [NDUT][$];
  logic [31:0] last_ret [NDUT];
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    data_sram_resp #(
      .ADDR_W(ADDR_W),
      .RD_LAT(d + 1)
    ) u_dut (
      .clk              (clk),
      .resetn           (resetn),
      .data_sram_en     (en),
      .data_sram_we     (we),
      .data_sram_addr   (addr),
      .data_sram_wdata  (wdata),
      .data_sram_rdata  (rdata_v[d]),
      .data_sram_rvalid (rvalid_v[d]),
      .misalign_err     (err_v[d])
    );
  end

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i = word_idx(a);
    return model_mem.exists(i) ? model_mem[i] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [WE_W-1:0] s,
                                      input logic [31:0] v);
    logic [31:0] w = model_read(a);
`ifdef DATA_SRAM_BYTE_WE_EN
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = v[8*b +: 8];
`else
    if (s[0]) w = v;
`endif
    model_mem[word_idx(a)] = w;
  endfunction

  // Monitor: pops one expectation per returned read and checks data, cycle and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (!resetn) begin
        exp_q[d].delete();
        last_ret[d] = RDATA_RST;
      end
      vectors++;
      if (rvalid_v[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_rvalid lat%0d: rvalid=1 rdata=%h at cycle %0d, required no return",
                   d + 1, rdata_v[d], cyc);
        end else begin
          e = exp_q[d].pop_front();
          if (rdata_v[d] !== e.data || cyc != e.due) begin
            miscompares++;
            $display("[TB] FAIL read_return lat%0d: got %h at cycle %0d, required %h at cycle %0d",
                     d + 1, rdata_v[d], cyc, e.data, e.due);
          end
          last_ret[d] = e.data;
        end
      end else begin
        if (rvalid_v[d] !== 1'b0 || rdata_v[d] !== last_ret[d]) begin
          miscompares++;
          $display("[TB] FAIL rdata_hold lat%0d: rvalid=%b rdata=%h, required rvalid=0 rdata=%h",
                   d + 1, rvalid_v[d], rdata_v[d], last_ret[d]);
        end
        if (exp_q[d].size() != 0 && exp_q[d][0].due <= cyc) begin
          miscompares++;
          $display("[TB] FAIL missing_return lat%0d: no rvalid at cycle %0d, required %h",
                   d + 1, cyc, exp_q[d][0].data);
          void'(exp_q[d].pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one request for a cycle; accepted reads are queued with their due cycle per instance.
  task automatic applyStimulus(input logic a_en, input logic [WE_W-1:0] a_we,
                               input logic [31:0] a_addr, input logic [31:0] a_wdata);
    en    = a_en;
    we    = a_we;
    addr  = a_addr;
    wdata = a_wdata;
    if (a_en && resetn) begin
      if (|a_we) model_write(a_addr, a_we, a_wdata);
      else for (int d = 0; d < NDUT; d++)
        exp_q[d].push_back('{due: cyc + d + 1, data: model_read(a_addr)});
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, WE_RD, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    applyStimulus(1'b1, WE_ALL, 32'h20, 32'hDEAD_BEEF);
    idle(2);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (rvalid_v[d] !== 1'b0 || rdata_v[d] !== RDATA_RST || err_v[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_state lat%0d: rvalid=%b rdata=%h err=%b, required 0 %h 0",
                 d + 1, rvalid_v[d], rdata_v[d], err_v[d], RDATA_RST);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_power_up_zero();
    applyStimulus(1'b1, WE_RD, 32'h20, 32'h0);
    applyStimulus(1'b1, WE_RD, 32'h3FFC, 32'h0);
    idle(4);
  endtask

  task automatic test_write_read();
    applyStimulus(1'b1, WE_ALL, 32'h100, 32'h1234_5678);
    applyStimulus(1'b1, WE_RD, 32'h100, 32'h0);
    idle(4);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, WE_ALL, 32'h0, 32'hA0A0_0001);
    applyStimulus(1'b1, WE_ALL, 32'h4, 32'hB0B0_0002);
    applyStimulus(1'b1, WE_ALL, 32'h8, 32'hC0C0_0003);
    applyStimulus(1'b1, WE_RD, 32'h0, 32'h0);
    applyStimulus(1'b1, WE_RD, 32'h4, 32'h0);
    applyStimulus(1'b1, WE_RD, 32'h8, 32'h0);
    idle(5);
  endtask

  task automatic test_byte_write();
    applyStimulus(1'b1, WE_ALL, 32'h200, 32'hAABB_CCDD);
`ifdef DATA_SRAM_BYTE_WE_EN
    applyStimulus(1'b1, 4'b0010, 32'h200, 32'h0000_1100);
`else
    applyStimulus(1'b1, 1'b1, 32'h200, 32'h0000_1100);
`endif
    applyStimulus(1'b1, WE_RD, 32'h200, 32'h0);
    idle(4);
  endtask

  task automatic test_wrap();
    applyStimulus(1'b1, WE_ALL, 32'h4000, 32'hCAFE_F00D);
    applyStimulus(1'b1, WE_RD, 32'h0, 32'h0);
    applyStimulus(1'b1, WE_ALL, 32'h3FFC, 32'h5A5A_0FF0);
    applyStimulus(1'b1, WE_RD, 32'h7FFC, 32'h0);
    idle(4);
  endtask

  task automatic test_enable_ignored();
    applyStimulus(1'b0, WE_ALL, 32'h100, 32'hFFFF_FFFF);
    applyStimulus(1'b0, WE_RD, 32'h101, 32'h0);
    applyStimulus(1'b1, WE_RD, 32'h100, 32'h0);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (err_v[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_no_misalign lat%0d: err=%b, required 0", d + 1, err_v[d]);
      end
    end
  endtask

  task automatic test_misalign();
    applyStimulus(1'b1, WE_RD, 32'h6, 32'h0);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (err_v[d] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL misalign_set lat%0d: err=%b, required 1", d + 1, err_v[d]);
      end
    end
    idle(10);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (err_v[d] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL misalign_sticky lat%0d: err=%b, required 1", d + 1, err_v[d]);
      end
    end
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (err_v[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL misalign_clear lat%0d: err=%b, required 0", d + 1, err_v[d]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    applyStimulus(1'b1, WE_RD, 32'h100, 32'h0);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(5);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (rvalid_v[d] !== 1'b0 || rdata_v[d] !== RDATA_RST) begin
        miscompares++;
        $display("[TB] FAIL flush_after_reset lat%0d: rvalid=%b rdata=%h, required 0 %h",
                 d + 1, rvalid_v[d], rdata_v[d], RDATA_RST);
      end
    end
  endtask

  task automatic test_drain();
    idle(6);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (exp_q[d].size() != 0) begin
        miscompares++;
        $display("[TB] FAIL pending_reads lat%0d: %0d outstanding, required 0", d + 1, exp_q[d].size());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_power_up_zero();
    test_write_read();
    test_back_to_back();
    test_byte_write();
    test_wrap();
    test_enable_ignored();
    test_misalign();
    test_reset_mid_read();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-index bits; depth = 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; legal range 1..4.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_sram_en  in  1  access request this cycle.
REQ-006 SHALL have port data_sram_we  in  WE_W  write strobe; WE_W is set in Configuration.
REQ-007 SHALL have port data_sram_addr  in  32  byte address.
REQ-008 SHALL have port data_sram_wdata  in  32  write data.
REQ-009 SHALL have port data_sram_rdata  out  32  read data.
REQ-010 SHALL have port data_sram_rvalid  out  1  data_sram_rdata holds a returned read this cycle.
REQ-011 SHALL have port misalign_err  out  1  sticky flag: an access had data_sram_addr[1:0] != 0.

Function
REQ-012 SHALL accept one access per cycle when data_sram_en=1, with no backpressure.
REQ-013 SHALL index storage with data_sram_addr[ADDR_W+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
REQ-014 SHALL treat an access as a write when any strobe bit is 1, and as a read otherwise.
REQ-015 SHALL update the addressed word at the acceptance edge of a write, and SHALL NOT assert rvalid for that write.
REQ-016 SHALL sample array data for a read at the acceptance edge and present it exactly RD_LAT cycles later with data_sram_rvalid=1 for one cycle.
REQ-017 SHALL return back-to-back reads in issue order, one per cycle; the pipeline is RD_LAT stages of {valid, data}.
REQ-018 SHALL return new data for a read accepted the cycle after a write to the same word (no stale read).
REQ-019 SHALL hold data_sram_rdata at its last returned value while data_sram_rvalid=0.
REQ-020 SHALL set misalign_err on any accepted access with addr[1:0] != 0, SHALL still perform that access at the word index, and SHALL clear the flag only on reset.
REQ-021 SHALL ignore data_sram_we, data_sram_addr and data_sram_wdata when data_sram_en=0.

Reset
REQ-022 SHALL asynchronously clear all pipeline valid bits, data_sram_rdata (to 0x00000000), data_sram_rvalid and misalign_err while resetn=0.
REQ-023 SHALL NOT reset array contents; on an initial power-up the array is all zero.
REQ-024 SHALL discard reads in flight when reset asserts mid-operation; none are returned after deassertion.
REQ-025 SHALL ignore requests while resetn=0 and accept requests from the first rising edge after deassertion.

Configuration
REQ-026 SHALL, with DATA_SRAM_BYTE_WE_EN defined, use WE_W=4, where strobe bit i writes byte i (bits 8i+7:8i) and the other bytes are preserved.
REQ-027 SHALL, without DATA_SRAM_BYTE_WE_EN, use WE_W=1, where we=1 writes the full 32-bit word.

Structure
REQ-028 SHALL take the word width (32), the RD_LAT bounds, and the reset rdata value (0x00000000) from the shared mycpu package/header.
REQ-029 SHALL place the storage array in one sub-module, data_sram_array: a single-port synchronous RAM with write enables.
REQ-030 SHALL keep the latency pipeline and the error flag in data_sram_resp.

Verification
REQ-031 SHALL cover: write 0x12345678 @0x100, then read @0x100 with RD_LAT=1 -> next cycle rvalid=1, rdata=0x12345678.
REQ-032 SHALL cover: RD_LAT=3, reads @0x0, 0x4, 0x8 on consecutive cycles with contents A, B, C -> rvalid high 3 consecutive cycles starting 3 cycles after the first read, rdata A, B, C.
REQ-033 SHALL cover, with DATA_SRAM_BYTE_WE_EN: word=0xAABBCCDD, write we=4'b0010 wdata=0x00001100 -> readback 0xAABB11DD.
REQ-034 SHALL cover, with ADDR_W=12: write 0xCAFEF00D @0x4000, read @0x0 -> 0xCAFEF00D (wrap).
REQ-035 SHALL cover: read @0x6 -> misalign_err=1 and it stays 1 after 10 idle cycles; resetn pulse -> 0.
REQ-036 SHALL cover: RD_LAT=2, issue a read, assert resetn=0 the next cycle, release -> rvalid never asserts and rdata=0.
